// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA output path: pixel type, standard
// timing sets and the colour-bar palette used by the optional test pattern.
package vga_pkg;

  typedef logic [11:0] pix12_t;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } timing_t;

  localparam timing_t TIMING_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33
  };

  localparam timing_t TIMING_1024X768 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768, v_fp: 3, v_sync: 6, v_bp: 29
  };

  localparam pix12_t BAR_WHITE   = 12'hFFF;
  localparam pix12_t BAR_YELLOW  = 12'hFF0;
  localparam pix12_t BAR_CYAN    = 12'h0FF;
  localparam pix12_t BAR_GREEN   = 12'h0F0;
  localparam pix12_t BAR_MAGENTA = 12'hF0F;
  localparam pix12_t BAR_RED     = 12'hF00;
  localparam pix12_t BAR_BLUE    = 12'h00F;
  localparam pix12_t BAR_BLACK   = 12'h000;

  function automatic pix12_t bar_color(input logic [2:0] idx);
    pix12_t c;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      3'd7: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_out_delay_line.sv
// sync_delay_line: fixed-depth shift register; every stage loads rst_val on a
// synchronous reset so the output side sees idle values immediately.
module sync_delay_line #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] rst_val,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= rst_val;
      end
    end else begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[Depth-1];

endmodule

// File: rtl/vga_sync_out.sv
// Raster timing generator and blanked RGB/sync output stage.
// Define VGA_TEST_PATTERN_EN to add the test_mode port and colour-bar source.
module vga_sync_out
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = TIMING_640X480.h_active,
  parameter int unsigned H_FP       = TIMING_640X480.h_fp,
  parameter int unsigned H_SYNC     = TIMING_640X480.h_sync,
  parameter int unsigned H_BP       = TIMING_640X480.h_bp,
  parameter int unsigned V_ACTIVE   = TIMING_640X480.v_active,
  parameter int unsigned V_FP       = TIMING_640X480.v_fp,
  parameter int unsigned V_SYNC     = TIMING_640X480.v_sync,
  parameter int unsigned V_BP       = TIMING_640X480.v_bp,
  parameter int unsigned PIPE_DELAY = 3
) (
  input  logic        clock,
  input  logic        reset,
  output logic [10:0] hc,
  output logic [9:0]  vc,
  output logic        active,
  output logic        frame_start,
  input  logic [11:0] pix_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [10:0] hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  // Low for the first clock out of reset: the raster holds at (0,0) so that
  // frame_start is seen once reset has gone away.
  logic        started_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hc_q      <= '0;
      vc_q      <= '0;
      started_q <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (started_q) begin
      if (hc_q == 11'(H_TOTAL - 1)) begin
        hc_d = '0;
        vc_d = (vc_q == 10'(V_TOTAL - 1)) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 11'd1;
      end
    end
  end

  logic in_active, raw_hs, raw_vs;

  always_comb begin
    in_active = started_q && (hc_q < 11'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));
    raw_hs    = !((hc_q >= 11'(HS_START)) && (hc_q < 11'(HS_END)));
    raw_vs    = !((vc_q >= 10'(VS_START)) && (vc_q < 10'(VS_END)));
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign active      = in_active;
  assign frame_start = started_q && (hc_q == '0) && (vc_q == '0);

  // {hs, vs, active} delayed to line up with pix_in.
  logic [2:0] dly;

  sync_delay_line #(
    .Width(3),
    .Depth(PIPE_DELAY)
  ) u_sync_dly (
    .clock  (clock),
    .reset  (reset),
    .rst_val(3'b110),
    .din    ({raw_hs, raw_vs, in_active}),
    .dout   (dly)
  );

  pix12_t pix_sel;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [10:0] hc_dly;
  logic [2:0]  bar_idx;

  sync_delay_line #(
    .Width(11),
    .Depth(PIPE_DELAY)
  ) u_hc_dly (
    .clock  (clock),
    .reset  (reset),
    .rst_val(11'd0),
    .din    (hc_q),
    .dout   (hc_dly)
  );

  assign bar_idx = 3'(hc_dly / 11'(BAR_W));
  assign pix_sel = test_mode ? bar_color(bar_idx) : pix_in;
`else
  assign pix_sel = pix_in;
`endif

  logic   hs_q, vs_q;
  pix12_t rgb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= dly[2];
      vs_q  <= dly[1];
      rgb_q <= dly[0] ? pix_sel : '0;
    end
  end

  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_r  = rgb_q[11:8];
  assign vga_g  = rgb_q[7:4];
  assign vga_b  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_sync_out.sv
// Scoreboard bench for vga_sync_out using a shrunk raster so whole frames
// fit in a short run; expectations come from position arithmetic.
module tb_vga_sync_out;

  localparam int HA = 80, HF = 8, HS = 16, HB = 16;
  localparam int VA = 40, VF = 3, VS = 2, VB = 5;
  localparam int PD = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = PD + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pix_in = '0;
  logic        test_mode = 1'b0;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        active, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  always #5 clock = ~clock;

  vga_sync_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .hc         (hc),
    .vc         (vc),
    .active     (active),
    .frame_start(frame_start),
    .pix_in     (pix_in),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs)
  );

  typedef struct {
    int          at;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        act;
    logic        fs;
  } ctr_t;

  typedef struct {
    int          at;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pin_t;

  ctr_t ctr_q[$];
  pin_t pin_q[$];

  int total = 0;
  int bad = 0;
  int cyc = -1;
  bit sb_on = 1'b0;
  int hs_low = 0, vs_low = 0, rgb_on = 0, fs_cnt = 0;

  function automatic int px(input int p);
    return p % HT;
  endfunction

  function automatic int py(input int p);
    return (p / HT) % VT;
  endfunction

  function automatic bit vis(input int p);
    return (px(p) < HA) && (py(p) < VA);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // Monitor: compares whatever the scoreboard says is due this cycle.
  always @(negedge clock) begin : monitor
    ctr_t ce;
    pin_t pe;
    if (sb_on) begin
      while (ctr_q.size() > 0 && ctr_q[0].at == cyc) begin
        ce = ctr_q.pop_front();
        chk("hc", 32'(hc), 32'(ce.hc));
        chk("vc", 32'(vc), 32'(ce.vc));
        chk("active", 32'(active), 32'(ce.act));
        chk("frame_start", 32'(frame_start), 32'(ce.fs));
      end
      while (pin_q.size() > 0 && pin_q[0].at == cyc) begin
        pe = pin_q.pop_front();
        chk("vga_hs", 32'(vga_hs), 32'(pe.hs));
        chk("vga_vs", 32'(vga_vs), 32'(pe.vs));
        chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(pe.rgb));
      end
      if (cyc >= LAT && cyc < LAT + HT) begin
        if (!vga_hs) hs_low++;
        if ({vga_r, vga_g, vga_b} != 12'h000) rgb_on++;
      end
      if (cyc >= LAT && cyc < LAT + FRAME) begin
        if (!vga_vs) vs_low++;
        if (frame_start) fs_cnt++;
      end
    end
  end

  // mode 0: constant 12'hABC, 1: random, 2: pixel encodes its own raster position
  task automatic step(input int mode);
    ctr_t ce;
    pin_t pe;
    int p;
    logic [11:0] v;
    @(posedge clock);
    #1;
    cyc++;
    ce.at = cyc;
    ce.hc = 11'(px(cyc));
    ce.vc = 10'(py(cyc));
    ce.act = vis(cyc);
    ce.fs = (cyc % FRAME) == 0;
    ctr_q.push_back(ce);
    p = cyc - PD;
    if (mode == 0) v = 12'hABC;
    else if (mode == 2 && p >= 0) v = 12'(px(p) * VA + py(p));
    else v = 12'($urandom);
    pix_in = v;
    pe.at = cyc + 1;
    if (p < 0) begin
      pe.hs = 1'b1;
      pe.vs = 1'b1;
      pe.rgb = '0;
    end else begin
      pe.hs = !(px(p) >= HA + HF && px(p) < HA + HF + HS);
      pe.vs = !(py(p) >= VA + VF && py(p) < VA + VF + VS);
      pe.rgb = vis(p) ? v : 12'h000;
    end
    pin_q.push_back(pe);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_hc"}, 32'(hc), 32'd0);
    chk({tag, "_vc"}, 32'(vc), 32'd0);
    chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
    chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
    chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
  endtask

  task automatic start_raster();
    ctr_q.delete();
    pin_q.delete();
    hs_low = 0;
    vs_low = 0;
    rgb_on = 0;
    fs_cnt = 0;
    cyc = -1;
    sb_on = 1'b1;
  endtask

  initial begin
    int target;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset");
    reset = 1'b0;
    start_raster();

    // Reset lands when the raster sits at hc=30, vc=20 in the second frame.
    target = FRAME + 20 * HT + 30;
    for (int n = 0; n <= target; n++) begin
      step((n < HT + PD) ? 0 : (n < FRAME) ? 1 : 2);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    sb_on = 1'b0;
    check_idle("midreset");
    chk("line_hs_low", 32'(hs_low), 32'(HS));
    chk("line_rgb_on", 32'(rgb_on), 32'(HA));
    chk("frame_vs_low", 32'(vs_low), 32'(VS * HT));
    chk("frame_fs_cnt", 32'(fs_cnt), 32'd1);
    reset = 1'b0;
    start_raster();

    for (int n = 0; n < FRAME + 2 * HT; n++) begin
      step((n < FRAME / 2) ? 2 : 1);
    end
    @(negedge clock);
    sb_on = 1'b0;
    chk("restart_hs_low", 32'(hs_low), 32'(HS));
    chk("restart_vs_low", 32'(vs_low), 32'(VS * HT));
    chk("restart_fs_cnt", 32'(fs_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
